// File: rtl/move_input_conditioner_if.sv
// Button-to-game bundle: raw direction buttons in, move pulses out.
// master drives the raw buttons, slave (the conditioner) drives the moves.
interface move_input_conditioner_if;
    logic n_raw;
    logic s_raw;
    logic e_raw;
    logic w_raw;
    logic n;
    logic s;
    logic e;
    logic w;
    logic busy;
    logic conflict;

    modport master (
        output n_raw, s_raw, e_raw, w_raw,
        input  n, s, e, w, busy, conflict
    );

    modport slave (
        input  n_raw, s_raw, e_raw, w_raw,
        output n, s, e, w, busy, conflict
    );
endinterface

// File: rtl/move_input_conditioner.sv
// Turns four bouncing direction buttons into single-cycle move pulses.
// Ports: clk, reset (async, active-high), io.slave (raw buttons in,
// n/s/e/w move pulses, busy and conflict out).
module move_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    move_input_conditioner_if.slave  io
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    // channel order: 0=n 1=s 2=e 3=w (lowest index wins)
    logic [3:0] raw;
    logic [3:0] deb;
    logic [3:0] deb_q;
    logic [3:0] rise;

    assign raw = {io.w_raw, io.e_raw, io.s_raw, io.n_raw};

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [CW-1:0]          cnt;
        logic                   sync_x;

        assign sync_x = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
                cnt    <= '0;
                deb[i] <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
                if (sync_x == deb[i]) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    // level held long enough: accept it
                    deb[i] <= sync_x;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign rise = deb & ~deb_q;

    state_t     state;
    logic [3:0] mv;
    logic       busy_q;
    logic       conf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            deb_q  <= '0;
            mv     <= '0;
            busy_q <= 1'b0;
            conf_q <= 1'b0;
        end else begin
            deb_q  <= deb;
            mv     <= '0;
            conf_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|rise) begin
                        // isolate lowest set bit = N>S>E>W priority
                        mv     <= rise & (~rise + 4'd1);
                        // more than one bit set
                        conf_q <= |(rise & (rise - 4'd1));
                        busy_q <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (deb == 4'd0) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign io.n        = mv[0];
    assign io.s        = mv[1];
    assign io.e        = mv[2];
    assign io.w        = mv[3];
    assign io.busy     = busy_q;
    assign io.conflict = conf_q;
endmodule

// File: tb/tb_move_input_conditioner.sv
// Directed bench for move_input_conditioner with a history-window model.
// Checks every cycle against the model plus literal latency/count pins.
module tb_move_input_conditioner;
    localparam int S = 2;
    localparam int D = 4;

    logic clk;
    logic reset;

    move_input_conditioner_if bus ();

    move_input_conditioner #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int ecount  = 0;

    // model state: index 0=n 1=s 2=e 3=w
    bit   samp [4][$];
    bit [3:0] deb_m;
    bit [3:0] debq_m;
    bit [3:0] mv_m;
    bit   conf_m;
    bit   hold_m;
    int   k;

    // observed pulse statistics: 0..3 moves, 4 conflict
    int pcount [5];
    int plast  [5];
    int bhigh  = 0;

    function automatic bit [3:0] rawv();
        return {bus.w_raw, bus.e_raw, bus.s_raw, bus.n_raw};
    endfunction

    // synced value seen before edge j = raw sampled S edges earlier
    function automatic bit syncval(int c, int j);
        if (j - S < 0) return 1'b0;
        return samp[c][j-S];
    endfunction

    // level flips once the last D synced samples all disagree with it
    function automatic bit win(int c, int kk, bit want);
        for (int j = kk - D + 1; j <= kk; j++)
            if (syncval(c, j) != want) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) samp[c].delete();
        deb_m  = '0;
        debq_m = '0;
        mv_m   = '0;
        conf_m = 1'b0;
        hold_m = 1'b0;
        k      = 0;
    endtask

    task automatic model_edge();
        bit [3:0] rise;
        bit [3:0] r;
        bit       found;
        if (reset) begin
            model_reset();
            return;
        end
        rise   = deb_m & ~debq_m;
        mv_m   = '0;
        conf_m = 1'b0;
        if (!hold_m) begin
            if (rise != 0) begin
                found = 1'b0;
                for (int c = 0; c < 4; c++)
                    if (rise[c] && !found) begin
                        mv_m[c] = 1'b1;
                        found   = 1'b1;
                    end
                conf_m = ($countones(rise) > 1);
                hold_m = 1'b1;
            end
        end else if (deb_m == 0) begin
            hold_m = 1'b0;
        end
        debq_m = deb_m;
        r = rawv();
        for (int c = 0; c < 4; c++) begin
            if (win(c, k, ~deb_m[c])) deb_m[c] = ~deb_m[c];
            samp[c].push_back(r[c]);
        end
        k++;
    endtask

    task automatic check();
        bit [3:0] got;
        got = {bus.w, bus.e, bus.s, bus.n};
        vectors++;
        if (got !== mv_m || bus.busy !== hold_m
            || bus.conflict !== conf_m) begin
            errors++;
            $display("FAIL cyc%0d: mv got %b want %b busy got %b want %b conf got %b want %b",
                     ecount, got, mv_m, bus.busy, hold_m,
                     bus.conflict, conf_m);
        end
        for (int c = 0; c < 4; c++)
            if (got[c] === 1'b1) begin
                pcount[c]++;
                plast[c] = ecount;
            end
        if (bus.conflict === 1'b1) begin
            pcount[4]++;
            plast[4] = ecount;
        end
        if (bus.busy === 1'b1) bhigh++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        ecount++;
        @(negedge clk);
        check();
    endtask

    task automatic chk(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic wait_idle(output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (at < 0 && bus.busy === 1'b0) at = ecount;
            if (at >= 0) break;
        end
        chk("idle_timeout", (at >= 0) ? 1 : 0, 1);
    endtask

    int e0;
    int at;
    int b[5];
    int bb;

    task automatic snap();
        for (int c = 0; c < 5; c++) b[c] = pcount[c];
        bb = bhigh;
    endtask

    initial begin
        for (int c = 0; c < 5; c++) begin
            pcount[c] = 0;
            plast[c]  = -1;
        end
        reset     = 1'b1;
        bus.n_raw = 1'b0;
        bus.s_raw = 1'b0;
        bus.e_raw = 1'b0;
        bus.w_raw = 1'b0;
        model_reset();
        repeat (2) step();
        chk("rst_moves",
            {28'd0, bus.w, bus.e, bus.s, bus.n}, 0);
        chk("rst_busy_conf", {bus.busy, bus.conflict}, 0);
        reset = 1'b0;
        repeat (3) step();

        // clean press and release
        snap();
        bus.n_raw = 1'b1;
        e0 = ecount + 1;
        repeat (10) step();
        chk("t1_n_count", pcount[0] - b[0], 1);
        chk("t1_n_edge", plast[0], e0 + 6);
        chk("t1_busy", int'(bus.busy), 1);
        bus.n_raw = 1'b0;
        e0 = ecount + 1;
        wait_idle(at);
        chk("t1_rel_edge", at, e0 + 6);

        // bounce then settle high
        snap();
        for (int sg = 0; sg < 10; sg++) begin
            bus.e_raw = (sg % 2 == 0);
            repeat (2) step();
        end
        bus.e_raw = 1'b1;
        e0 = ecount + 1;
        repeat (10) step();
        chk("t2_e_count", pcount[2] - b[2], 1);
        chk("t2_e_edge", plast[2], e0 + 6);
        bus.e_raw = 1'b0;
        wait_idle(at);

        // glitch shorter than debounce
        snap();
        bus.w_raw = 1'b1;
        repeat (3) step();
        bus.w_raw = 1'b0;
        repeat (10) step();
        chk("t3_w_count", pcount[3] - b[3], 0);
        chk("t3_busy_cyc", bhigh - bb, 0);

        // simultaneous south+east
        snap();
        bus.s_raw = 1'b1;
        bus.e_raw = 1'b1;
        e0 = ecount + 1;
        repeat (10) step();
        chk("t4_s_count", pcount[1] - b[1], 1);
        chk("t4_conf_count", pcount[4] - b[4], 1);
        chk("t4_conf_edge", plast[4], e0 + 6);
        chk("t4_e_count", pcount[2] - b[2], 0);
        bus.s_raw = 1'b0;
        bus.e_raw = 1'b0;
        wait_idle(at);

        // second press while held, then fresh press
        snap();
        bus.n_raw = 1'b1;
        repeat (10) step();
        bus.w_raw = 1'b1;
        repeat (12) step();
        chk("t5_w_held", pcount[3] - b[3], 0);
        chk("t5_n_count", pcount[0] - b[0], 1);
        bus.n_raw = 1'b0;
        bus.w_raw = 1'b0;
        wait_idle(at);
        bus.w_raw = 1'b1;
        e0 = ecount + 1;
        repeat (10) step();
        chk("t5_w_count", pcount[3] - b[3], 1);
        chk("t5_w_edge", plast[3], e0 + 6);
        bus.w_raw = 1'b0;
        wait_idle(at);

        // reset mid-qualification, button held through
        snap();
        bus.n_raw = 1'b1;
        repeat (5) step();
        reset = 1'b1;
        #1;
        chk("t6_rst_out",
            {26'd0, bus.busy, bus.conflict,
             bus.w, bus.e, bus.s, bus.n}, 0);
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        e0 = ecount + 1;
        repeat (10) step();
        chk("t6_n_count", pcount[0] - b[0], 1);
        chk("t6_n_edge", plast[0], e0 + 6);

        // reset while busy clears it at once
        chk("t6_busy_pre", int'(bus.busy), 1);
        reset = 1'b1;
        #1;
        chk("t6_busy_rst", int'(bus.busy), 0);
        model_reset();
        step();
        bus.n_raw = 1'b0;
        reset = 1'b0;
        repeat (10) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end
endmodule
